// File: rtl/apb_program_loader.sv
// Streams host instruction words into a core's instruction memory over APB, runs the core
// until run_complete or a cycle timeout, then serves single-word APB read-backs.
module apb_program_loader #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 12,
  parameter int BASE_ADDR      = 0,
  parameter int ADDR_STEP      = 4,
  parameter int RUN_TIMEOUT    = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_req,
  input  logic [ADDRESS_LENGTH-1:0] load_words,
  input  logic                      s_valid,
  input  logic [DATA_LENGTH-1:0]    s_data,
  output logic                      s_ready,
  input  logic                      rd_req,
  input  logic [ADDRESS_LENGTH-1:0] rd_addr,
  output logic                      rd_valid,
  output logic [DATA_LENGTH-1:0]    rd_data,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [ADDRESS_LENGTH-1:0] apb_addr,
  output logic [DATA_LENGTH-1:0]    apb_wdata,
  output logic                      apb_psel,
  output logic                      apb_pwrite,
  output logic                      apb_pready,
  input  logic [DATA_LENGTH-1:0]    apb_rdata,
  output logic                      instr_load_start,
  output logic                      core_select,
  input  logic                      run_complete
);

  localparam int TIMER_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
  localparam logic [ADDRESS_LENGTH-1:0] BASE = ADDRESS_LENGTH'(BASE_ADDR);
  localparam logic [ADDRESS_LENGTH-1:0] STEP = ADDRESS_LENGTH'(ADDR_STEP);
  localparam logic [TIMER_W-1:0]        TMAX = TIMER_W'(RUN_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_LOAD_SETUP,
    S_LOAD_ACCESS,
    S_RUN,
    S_DONE,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_RD_CAPTURE
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDRESS_LENGTH-1:0]   addr_q, addr_d;
  logic [DATA_LENGTH-1:0]      wdata_q, wdata_d;
  logic [ADDRESS_LENGTH-1:0]   count_q, count_d;
  logic [ADDRESS_LENGTH-1:0]   words_q, words_d;
  logic [TIMER_W-1:0]          timer_q, timer_d;
  logic                        timeout_err_q, timeout_err_d;
  logic [DATA_LENGTH-1:0]      rd_data_q, rd_data_d;
  logic                        rd_from_done_q, rd_from_done_d;
  logic [ADDRESS_LENGTH-1:0]   count_inc;

  assign count_inc = count_q + ADDRESS_LENGTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= BASE;
      wdata_q        <= '0;
      count_q        <= '0;
      words_q        <= '0;
      timer_q        <= '0;
      timeout_err_q  <= 1'b0;
      rd_data_q      <= '0;
      rd_from_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      count_q        <= count_d;
      words_q        <= words_d;
      timer_q        <= timer_d;
      timeout_err_q  <= timeout_err_d;
      rd_data_q      <= rd_data_d;
      rd_from_done_q <= rd_from_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    count_d        = count_q;
    words_d        = words_q;
    timer_d        = timer_q;
    timeout_err_d  = timeout_err_q;
    rd_data_d      = rd_data_q;
    rd_from_done_d = rd_from_done_q;

    case (state_q)
      // A load request takes priority over a simultaneous read request.
      S_IDLE, S_DONE: begin
        if (load_req && (load_words != '0)) begin
          state_d       = S_LOAD_WAIT;
          timeout_err_d = 1'b0;
          addr_d        = BASE;
          count_d       = '0;
          words_d       = load_words;
        end else if (rd_req) begin
          state_d        = S_RD_SETUP;
          addr_d         = rd_addr;
          rd_from_done_d = (state_q == S_DONE);
        end
      end
      S_LOAD_WAIT: begin
        if (s_valid) begin
          wdata_d = s_data;
          state_d = S_LOAD_SETUP;
        end
      end
      S_LOAD_SETUP: state_d = S_LOAD_ACCESS;
      S_LOAD_ACCESS: begin
        addr_d  = addr_q + STEP;
        count_d = count_inc;
        if (count_inc == words_q) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          state_d = S_LOAD_WAIT;
        end
      end
      // Completion is checked first so it wins over a timeout in the same cycle.
      S_RUN: begin
        if (run_complete) begin
          state_d = S_DONE;
        end else if (timer_q == TMAX) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_RD_SETUP: state_d = S_RD_ACCESS;
      S_RD_ACCESS: begin
        rd_data_d = apb_rdata;
        state_d   = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: state_d = rd_from_done_q ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the registered state so they all fall with the asynchronous reset.
  assign s_ready          = (state_q == S_LOAD_WAIT);
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign apb_psel         = (state_q == S_LOAD_SETUP) || (state_q == S_LOAD_ACCESS) ||
                            (state_q == S_RD_SETUP)   || (state_q == S_RD_ACCESS);
  assign apb_pready       = (state_q == S_LOAD_ACCESS) || (state_q == S_RD_ACCESS);
  assign apb_pwrite       = (state_q == S_LOAD_SETUP) || (state_q == S_LOAD_ACCESS);
  assign instr_load_start = (state_q == S_LOAD_WAIT) || (state_q == S_LOAD_SETUP) ||
                            (state_q == S_LOAD_ACCESS);
  assign core_select      = (state_q == S_RUN);
  assign rd_valid         = (state_q == S_RD_CAPTURE);
  assign rd_data          = rd_data_q;
  assign timeout_err      = timeout_err_q;
  assign apb_addr         = addr_q;
  assign apb_wdata        = wdata_q;

endmodule

// File: tb/tb_apb_program_loader.sv
// Scoreboard bench for apb_program_loader: two instances share stimulus, one based at 0x000
// and one at 0xFFC so address wrap is observed on every load.
module tb_apb_program_loader;

  localparam int DW = 32;
  localparam int AW = 12;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req;
  logic [AW-1:0] load_words;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] apb_rdata;
  logic          run_complete;

  logic          s_ready, rd_valid, busy, timeout_err;
  logic [DW-1:0] rd_data, apb_wdata;
  logic [AW-1:0] apb_addr;
  logic          apb_psel, apb_pwrite, apb_pready, instr_load_start, core_select;

  logic          w_s_ready, w_rd_valid, w_busy, w_timeout_err;
  logic [DW-1:0] w_rd_data, w_apb_wdata;
  logic [AW-1:0] w_apb_addr;
  logic          w_apb_psel, w_apb_pwrite, w_apb_pready, w_instr_load_start, w_core_select;

  int checks = 0;
  int errors = 0;

  xfer_t         exp_q[$];
  xfer_t         expw_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] words[16];

  always #5 clk = ~clk;

  apb_program_loader #(
    .DATA_LENGTH(DW), .ADDRESS_LENGTH(AW), .BASE_ADDR(0), .ADDR_STEP(4), .RUN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_words(load_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .timeout_err(timeout_err),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_psel(apb_psel),
    .apb_pwrite(apb_pwrite), .apb_pready(apb_pready), .apb_rdata(apb_rdata),
    .instr_load_start(instr_load_start), .core_select(core_select),
    .run_complete(run_complete)
  );

  apb_program_loader #(
    .DATA_LENGTH(DW), .ADDRESS_LENGTH(AW), .BASE_ADDR(12'hFFC), .ADDR_STEP(4), .RUN_TIMEOUT(16)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_words(load_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(w_s_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
    .busy(w_busy), .timeout_err(w_timeout_err),
    .apb_addr(w_apb_addr), .apb_wdata(w_apb_wdata), .apb_psel(w_apb_psel),
    .apb_pwrite(w_apb_pwrite), .apb_pready(w_apb_pready), .apb_rdata(apb_rdata),
    .instr_load_start(w_instr_load_start), .core_select(w_core_select),
    .run_complete(run_complete)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Main instance: every ACCESS pops the scoreboard and checks both APB phases.
  logic          prev_psel, prev_pready, prev_pwrite;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  xfer_t         mon_x;
  logic [DW-1:0] mon_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_psel   = 1'b0;
      prev_pready = 1'b0;
    end else begin
      if (apb_psel && apb_pready) begin
        checkOutput("setup_phase", 32'({prev_psel, prev_pready}), 32'd2);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_xfer", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_x = exp_q.pop_front();
          checkOutput("access_addr", 32'(apb_addr), 32'(mon_x.addr));
          checkOutput("setup_addr", 32'(prev_addr), 32'(mon_x.addr));
          checkOutput("access_pwrite", 32'(apb_pwrite), 32'(mon_x.wr));
          checkOutput("setup_pwrite", 32'(prev_pwrite), 32'(mon_x.wr));
          if (mon_x.wr) begin
            checkOutput("access_wdata", apb_wdata, mon_x.data);
            checkOutput("setup_wdata", prev_wdata, mon_x.data);
            checkOutput("ils_in_write", 32'({instr_load_start, core_select}), 32'd2);
          end
        end
      end
      if (prev_psel && prev_pready) checkOutput("psel_release", 32'(apb_psel), 32'd0);
      if (s_ready)
        checkOutput("s_ready_state", 32'({apb_psel, instr_load_start, core_select}), 32'd2);
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_rd_valid", 32'(rd_q.size()), 32'd1);
        end else begin
          mon_rd = rd_q.pop_front();
          checkOutput("rd_data", rd_data, mon_rd);
        end
      end
      prev_psel   = apb_psel;
      prev_pready = apb_pready;
      prev_pwrite = apb_pwrite;
      prev_addr   = apb_addr;
      prev_wdata  = apb_wdata;
    end
  end

  // Wrapping instance: same traffic, write addresses offset from 0xFFC.
  logic          wprev_psel, wprev_pready;
  logic [AW-1:0] wprev_addr;
  xfer_t         wmon_x;

  always @(negedge clk) begin
    if (!rst_n) begin
      wprev_psel   = 1'b0;
      wprev_pready = 1'b0;
    end else begin
      if (w_apb_psel && w_apb_pready) begin
        checkOutput("w_setup_phase", 32'({wprev_psel, wprev_pready}), 32'd2);
        if (expw_q.size() == 0) begin
          checkOutput("w_unexpected_xfer", 32'(expw_q.size()), 32'd1);
        end else begin
          wmon_x = expw_q.pop_front();
          checkOutput("w_access_addr", 32'(w_apb_addr), 32'(wmon_x.addr));
          checkOutput("w_setup_addr", 32'(wprev_addr), 32'(wmon_x.addr));
          checkOutput("w_access_pwrite", 32'(w_apb_pwrite), 32'(wmon_x.wr));
          if (wmon_x.wr) checkOutput("w_access_wdata", w_apb_wdata, wmon_x.data);
        end
      end
      wprev_psel   = w_apb_psel;
      wprev_pready = w_apb_pready;
      wprev_addr   = w_apb_addr;
    end
  end

  task automatic pulseLoad(input int n, input bit alsoRead);
    @(posedge clk); #1;
    load_req   = 1'b1;
    load_words = AW'(n);
    if (alsoRead) begin
      rd_req  = 1'b1;
      rd_addr = 12'h010;
    end
    @(posedge clk); #1;
    load_req = 1'b0;
    rd_req   = 1'b0;
  endtask

  // Offers one word; with gaps set, s_valid is randomly dropped while waiting.
  task automatic sendWord(input logic [DW-1:0] w, input int idx, input bit gaps);
    int n;
    exp_q.push_back('{addr: AW'(idx * 4), data: w, wr: 1'b1});
    expw_q.push_back('{addr: AW'(12'hFFC + idx * 4), data: w, wr: 1'b1});
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (1) begin
      if (s_valid && s_ready) begin
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = $urandom;
        break;
      end
      n++;
      if (n > 200) begin
        checkOutput("s_ready_wait", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        break;
      end
      @(negedge clk);
      if (gaps) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = s_valid ? w : $urandom;
      end
    end
  endtask

  task automatic applyStimulus(input int n, input bit gaps, input bit alsoRead);
    longint t, tprev;
    pulseLoad(n, alsoRead);
    @(negedge clk);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_s_ready", 32'(s_ready), 32'd1);
    checkOutput("load_clears_tmo", 32'(timeout_err), 32'd0);
    checkOutput("load_no_psel", 32'(apb_psel), 32'd0);
    tprev = 0;
    for (int i = 0; i < n; i++) begin
      sendWord(words[i], i, gaps);
      t = $time;
      if (!gaps && i > 0) checkOutput("throughput", 32'(t - tprev), 32'd30);
      tprev = t;
    end
  endtask

  // Counts RUN cycles; optionally raises run_complete during RUN cycle complete_at.
  task automatic waitRun(input int complete_at, output int run_cycles, output int first_cs);
    int n;
    run_cycles = 0;
    first_cs   = 0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) break;
      if (core_select) begin
        if (first_cs == 0) first_cs = n;
        run_cycles++;
        checkOutput("ils_in_run", 32'(instr_load_start), 32'd0);
        if (run_cycles == complete_at) begin
          run_complete = 1'b1;
          @(posedge clk); #1;
          run_complete = 1'b0;
        end
      end
    end
    if (n >= 200) checkOutput("run_wait", 32'(busy), 32'd0);
  endtask

  task automatic doRead(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{addr: a, data: '0, wr: 1'b0});
    expw_q.push_back('{addr: a, data: '0, wr: 1'b0});
    rd_q.push_back(d);
    apb_rdata = $urandom;
    @(posedge clk); #1;
    rd_req  = 1'b1;
    rd_addr = a;
    @(posedge clk); #1;
    rd_req  = 1'b0;
    rd_addr = AW'($urandom);
    @(negedge clk);
    checkOutput("rd_valid_setup", 32'(rd_valid), 32'd0);
    apb_rdata = d;
    @(negedge clk);
    checkOutput("rd_valid_access", 32'(rd_valid), 32'd0);
    @(negedge clk);
    checkOutput("rd_valid_pulse", 32'(rd_valid), 32'd1);
    apb_rdata = $urandom;
    @(negedge clk);
    checkOutput("rd_valid_end", 32'({rd_valid, busy}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rc, fc, k;
    rst_n = 1'b0; load_req = 1'b0; load_words = '0; s_valid = 1'b0; s_data = '0;
    rd_req = 1'b0; rd_addr = '0; apb_rdata = '0; run_complete = 1'b0;
    foreach (words[i]) words[i] = $urandom;
    repeat (2) @(negedge clk);
    checkOutput("rst_ctrl", 32'({busy, s_ready, core_select, instr_load_start, rd_valid, timeout_err}), 32'd0);
    checkOutput("rst_apb", 32'({apb_psel, apb_pready, apb_pwrite}), 32'd0);
    checkOutput("rst_addr", 32'(apb_addr), 32'd0);
    checkOutput("rst_wdata", apb_wdata, 32'd0);
    rst_n = 1'b1;

    words[0] = 32'h00500093; words[1] = 32'h00100113; words[2] = 32'h002081B3;
    applyStimulus(3, 1'b0, 1'b0);
    waitRun(5, rc, fc);
    checkOutput("run_len_complete", 32'(rc), 32'd5);
    checkOutput("core_rise_after_access", 32'(fc), 32'd3);
    checkOutput("done_state", 32'({busy, core_select, timeout_err}), 32'd0);

    doRead(12'h008, 32'hDEADBEEF);
    doRead(12'h004, 32'h0BADF00D);

    words[0] = $urandom; words[1] = $urandom;
    applyStimulus(2, 1'b0, 1'b0);
    waitRun(0, rc, fc);
    checkOutput("timeout_len", 32'(rc), 32'd16);
    checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
    checkOutput("timeout_done", 32'({busy, core_select}), 32'd0);

    foreach (words[i]) words[i] = $urandom;
    applyStimulus(12, 1'b1, 1'b0);
    waitRun(16, rc, fc);
    checkOutput("complete_at_limit_len", 32'(rc), 32'd16);
    checkOutput("complete_wins", 32'(timeout_err), 32'd0);

    applyStimulus(2, 1'b0, 1'b1);
    waitRun(3, rc, fc);
    checkOutput("collision_run_len", 32'(rc), 32'd3);

    pulseLoad(2, 1'b0);
    sendWord(words[0], 0, 1'b0);
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (apb_psel && apb_pready) break;
    end
    checkOutput("reached_access", 32'(apb_psel && apb_pready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_ctrl", 32'({busy, s_ready, core_select, instr_load_start, rd_valid, timeout_err}), 32'd0);
    checkOutput("arst_apb", 32'({apb_psel, apb_pready, apb_pwrite, w_apb_psel, w_apb_pready}), 32'd0);
    checkOutput("arst_addr", 32'(apb_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("arst_queue_empty", 32'(exp_q.size()), 32'd0);

    pulseLoad(0, 1'b0);
    @(negedge clk);
    checkOutput("zero_load_ignored", 32'({busy, s_ready, instr_load_start}), 32'd0);
    doRead(12'hABC, 32'h5A5AA5A5);

    checkOutput("final_exp_q", 32'(exp_q.size()), 32'd0);
    checkOutput("final_expw_q", 32'(expw_q.size()), 32'd0);
    checkOutput("final_rd_q", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
